// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter.
//   MEM_ADDR_W              : word-address width of the data memory
//   MEM_NONE/BYTE/HALFWORD/WORD : access size codes on ctrl_mem_read/write
// size_valid() reports whether a code requests an access. norm_size() maps
// any code that is not a real size to MEM_NONE.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 8;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] BYTE     = 2'b01;
  localparam logic [1:0] HALFWORD = 2'b10;
  localparam logic [1:0] WORD     = 2'b11;

  function automatic logic size_valid(input logic [1:0] code);
    return (code == BYTE) || (code == HALFWORD) || (code == WORD);
  endfunction

  function automatic logic [1:0] norm_size(input logic [1:0] code);
    return size_valid(code) ? code : MEM_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating wait counter that guards port 1 against starvation.
//   i_clk    : clock
//   i_n_rst  : synchronous active-low reset
//   i_inc    : port 1 was refused this cycle
//   i_clr    : port 1 was granted or is not requesting
//   o_at_max : counter has reached MAX_WAIT
module starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_n_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single data memory.
// Port 0 is the pipeline MEM stage, port 1 the debug/loader port.
//   clk_i, n_rst_i              : clock, synchronous active-low reset
//   pX_req_i / fields           : request with address, store data, size codes
//   pX_gnt_o                    : combinational accept
//   p0_stall_o                  : port 0 requesting but not accepted
//   pX_read_data_o, pX_rvalid_o : registered read return, 2 cycles after grant
//   mem_*_o                     : memory command, one cycle after grant
//   mem_read_data_i             : combinational read data from memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,

  input  logic                  p0_req_i,
  input  logic [MEM_ADDR_W-1:0] p0_address_i,
  input  logic [31:0]           p0_write_data_i,
  input  logic [1:0]            p0_ctrl_mem_read_i,
  input  logic [1:0]            p0_ctrl_mem_write_i,
  output logic                  p0_gnt_o,
  output logic                  p0_stall_o,
  output logic [31:0]           p0_read_data_o,
  output logic                  p0_rvalid_o,

  input  logic                  p1_req_i,
  input  logic [MEM_ADDR_W-1:0] p1_address_i,
  input  logic [31:0]           p1_write_data_i,
  input  logic [1:0]            p1_ctrl_mem_read_i,
  input  logic [1:0]            p1_ctrl_mem_write_i,
  output logic                  p1_gnt_o,
  output logic [31:0]           p1_read_data_o,
  output logic                  p1_rvalid_o,

  output logic [MEM_ADDR_W-1:0] mem_address_o,
  output logic [31:0]           mem_write_data_o,
  output logic [1:0]            mem_ctrl_mem_read_o,
  output logic [1:0]            mem_ctrl_mem_write_o,
  input  logic [31:0]           mem_read_data_i
);

  // A request carrying both a read and a write is a write only.
  logic [1:0] w_p0_wr, w_p0_rd, w_p1_wr, w_p1_rd;

  assign w_p0_wr = norm_size(p0_ctrl_mem_write_i);
  assign w_p0_rd = size_valid(w_p0_wr) ? MEM_NONE : norm_size(p0_ctrl_mem_read_i);
  assign w_p1_wr = norm_size(p1_ctrl_mem_write_i);
  assign w_p1_rd = size_valid(w_p1_wr) ? MEM_NONE : norm_size(p1_ctrl_mem_read_i);

  logic w_at_max;
  logic w_p1_win;
  logic w_p0_gnt, w_p1_gnt;
  logic w_p1_refused;

  // Port 1 takes the slot when port 0 is idle or its wait has saturated.
  assign w_p1_win = p1_req_i & (~p0_req_i | w_at_max);

  assign w_p0_gnt = n_rst_i & p0_req_i & ~w_p1_win;
  assign w_p1_gnt = n_rst_i & w_p1_win;

  assign p0_gnt_o   = w_p0_gnt;
  assign p1_gnt_o   = w_p1_gnt;
  assign p0_stall_o = n_rst_i & p0_req_i & ~w_p0_gnt;

  assign w_p1_refused = p1_req_i & ~w_p1_gnt;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .i_clk    (clk_i),
    .i_n_rst  (n_rst_i),
    .i_inc    (w_p1_refused),
    .i_clr    (w_p1_gnt | ~p1_req_i),
    .o_at_max (w_at_max)
  );

  logic                  w_sel_gnt;
  logic                  w_sel_port;
  logic [MEM_ADDR_W-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [1:0]            w_sel_rd, w_sel_wr;

  always_comb begin
    w_sel_gnt   = w_p0_gnt | w_p1_gnt;
    w_sel_port  = 1'b0;
    w_sel_addr  = p0_address_i;
    w_sel_wdata = p0_write_data_i;
    w_sel_rd    = w_p0_rd;
    w_sel_wr    = w_p0_wr;
    if (w_p1_gnt) begin
      w_sel_port  = 1'b1;
      w_sel_addr  = p1_address_i;
      w_sel_wdata = p1_write_data_i;
      w_sel_rd    = w_p1_rd;
      w_sel_wr    = w_p1_wr;
    end
  end

  logic                  r_cmd_valid;
  logic                  r_cmd_port;
  logic [MEM_ADDR_W-1:0] r_cmd_addr;
  logic [31:0]           r_cmd_wdata;
  logic [1:0]            r_cmd_rd, r_cmd_wr;

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      r_cmd_valid <= 1'b0;
      r_cmd_port  <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_rd    <= MEM_NONE;
      r_cmd_wr    <= MEM_NONE;
    end else if (w_sel_gnt) begin
      r_cmd_valid <= 1'b1;
      r_cmd_port  <= w_sel_port;
      r_cmd_addr  <= w_sel_addr;
      r_cmd_wdata <= w_sel_wdata;
      r_cmd_rd    <= w_sel_rd;
      r_cmd_wr    <= w_sel_wr;
    end else begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Reset gates the memory command combinationally so an access caught
  // in flight by reset never writes.
  logic w_mem_active;

  assign w_mem_active         = r_cmd_valid & n_rst_i;
  assign mem_address_o        = w_mem_active ? r_cmd_addr  : '0;
  assign mem_write_data_o     = w_mem_active ? r_cmd_wdata : '0;
  assign mem_ctrl_mem_read_o  = w_mem_active ? r_cmd_rd    : MEM_NONE;
  assign mem_ctrl_mem_write_o = w_mem_active ? r_cmd_wr    : MEM_NONE;

  logic w_rd_done;
  assign w_rd_done = w_mem_active & size_valid(r_cmd_rd);

  logic [31:0] r_p0_rdata, r_p1_rdata;
  logic        r_p0_rvalid, r_p1_rvalid;

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
    end else begin
      r_p0_rvalid <= w_rd_done & ~r_cmd_port;
      r_p1_rvalid <= w_rd_done &  r_cmd_port;
      if (w_rd_done && !r_cmd_port) r_p0_rdata <= mem_read_data_i;
      if (w_rd_done &&  r_cmd_port) r_p1_rdata <= mem_read_data_i;
    end
  end

  assign p0_read_data_o = r_p0_rdata;
  assign p1_read_data_o = r_p1_rdata;
  assign p0_rvalid_o    = r_p0_rvalid;
  assign p1_rvalid_o    = r_p1_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural data memory and a
// read-return scoreboard checked by an independent monitor.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        p0_req, p1_req;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wd, p1_wd;
  logic [1:0]  p0_rd, p0_wr, p1_rd, p1_wr;
  logic        p0_gnt, p1_gnt, p0_stall;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_rvalid, p1_rvalid;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wd, mem_rdata;
  logic [1:0]  mem_rd, mem_wr;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk_i               (clk),
    .n_rst_i             (n_rst),
    .p0_req_i            (p0_req),
    .p0_address_i        (p0_addr),
    .p0_write_data_i     (p0_wd),
    .p0_ctrl_mem_read_i  (p0_rd),
    .p0_ctrl_mem_write_i (p0_wr),
    .p0_gnt_o            (p0_gnt),
    .p0_stall_o          (p0_stall),
    .p0_read_data_o      (p0_rdata),
    .p0_rvalid_o         (p0_rvalid),
    .p1_req_i            (p1_req),
    .p1_address_i        (p1_addr),
    .p1_write_data_i     (p1_wd),
    .p1_ctrl_mem_read_i  (p1_rd),
    .p1_ctrl_mem_write_i (p1_wr),
    .p1_gnt_o            (p1_gnt),
    .p1_read_data_o      (p1_rdata),
    .p1_rvalid_o         (p1_rvalid),
    .mem_address_o       (mem_addr),
    .mem_write_data_o    (mem_wd),
    .mem_ctrl_mem_read_o (mem_rd),
    .mem_ctrl_mem_write_o(mem_wr),
    .mem_read_data_i     (mem_rdata)
  );

  // Behavioural data memory: sized, sign-extended reads from the low lane.
  logic [31:0] mem_model [256] = '{default: 32'h0};

  always @(posedge clk) begin
    case (mem_wr)
      WORD:     mem_model[mem_addr]        <= mem_wd;
      HALFWORD: mem_model[mem_addr][15:0]  <= mem_wd[15:0];
      BYTE:     mem_model[mem_addr][7:0]   <= mem_wd[7:0];
      default:  ;
    endcase
  end

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_rd)
      WORD:     mem_rdata = mem_model[mem_addr];
      HALFWORD: mem_rdata = {{16{mem_model[mem_addr][15]}}, mem_model[mem_addr][15:0]};
      BYTE:     mem_rdata = {{24{mem_model[mem_addr][7]}}, mem_model[mem_addr][7:0]};
      default:  mem_rdata = 32'h0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called in the grant cycle; data returns two cycles later.
  task automatic expect_read(input bit port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic check_rv(input bit port, input logic [31:0] data);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_rvalid: port %0d data %h at cycle %0d, none expected", port, data, cyc);
    end else begin
      e = sb.pop_front();
      if (e.port != port || e.data !== data || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL read_return: got port %0d data %h cycle %0d expected port %0d data %h cycle %0d",
                 port, data, cyc, e.port, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (p0_rvalid) check_rv(1'b0, p0_rdata);
    if (p1_rvalid) check_rv(1'b1, p1_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic [7:0] a, input logic [31:0] d,
                        input logic [1:0] rd, input logic [1:0] wr);
    p0_req = req; p0_addr = a; p0_wd = d; p0_rd = rd; p0_wr = wr;
  endtask

  task automatic drive1(input logic req, input logic [7:0] a, input logic [31:0] d,
                        input logic [1:0] rd, input logic [1:0] wr);
    p1_req = req; p1_addr = a; p1_wd = d; p1_rd = rd; p1_wr = wr;
  endtask

  task automatic idle_all();
    drive0(1'b0, 8'h0, 32'h0, MEM_NONE, MEM_NONE);
    drive1(1'b0, 8'h0, 32'h0, MEM_NONE, MEM_NONE);
  endtask

  initial begin
    n_rst = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_p0_rvalid", {31'h0, p0_rvalid}, 32'h0);
    chk("rst_p1_rvalid", {31'h0, p1_rvalid}, 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_mem_wr", {30'h0, mem_wr}, {30'h0, MEM_NONE});

    // Word write then word read of 0x10.
    tick();
    n_rst = 1'b1;
    drive0(1'b1, 8'h10, 32'hDEADBEEF, MEM_NONE, WORD);
    @(negedge clk);
    chk("t1_wr_p0_gnt", {31'h0, p0_gnt}, 32'h1);
    chk("t1_wr_p0_stall", {31'h0, p0_stall}, 32'h0);
    chk("t1_wr_p1_gnt", {31'h0, p1_gnt}, 32'h0);
    tick();
    drive0(1'b1, 8'h10, 32'h0, WORD, MEM_NONE);
    @(negedge clk);
    chk("t1_rd_p0_gnt", {31'h0, p0_gnt}, 32'h1);
    chk("t1_mem_addr", {24'h0, mem_addr}, 32'h10);
    chk("t1_mem_wr", {30'h0, mem_wr}, {30'h0, WORD});
    chk("t1_mem_wd", mem_wd, 32'hDEADBEEF);
    expect_read(1'b0, 32'hDEADBEEF);
    tick();
    idle_all();
    @(negedge clk);
    chk("t1_mem_rd", {30'h0, mem_rd}, {30'h0, WORD});

    // Write 0x20 then read 0x20 back to back.
    tick();
    drive0(1'b1, 8'h20, 32'hCAFEF00D, MEM_NONE, WORD);
    @(negedge clk);
    chk("t2_wr_gnt", {31'h0, p0_gnt}, 32'h1);
    tick();
    drive0(1'b1, 8'h20, 32'h0, WORD, MEM_NONE);
    @(negedge clk);
    chk("t2_rd_gnt", {31'h0, p0_gnt}, 32'h1);
    expect_read(1'b0, 32'hCAFEF00D);
    tick();
    idle_all();

    // Port 1 byte read of 0x00000080 sign-extends.
    tick();
    drive0(1'b1, 8'h30, 32'h00000080, MEM_NONE, WORD);
    @(negedge clk);
    chk("t3_wr_gnt", {31'h0, p0_gnt}, 32'h1);
    tick();
    drive0(1'b0, 8'h0, 32'h0, MEM_NONE, MEM_NONE);
    drive1(1'b1, 8'h30, 32'h0, BYTE, MEM_NONE);
    @(negedge clk);
    chk("t3_p1_gnt", {31'h0, p1_gnt}, 32'h1);
    chk("t3_p0_gnt", {31'h0, p0_gnt}, 32'h0);
    expect_read(1'b1, 32'hFFFFFF80);
    tick();
    idle_all();

    // Read and write both WORD: treated as a write, no read return.
    tick();
    drive0(1'b1, 8'h40, 32'h55AA55AA, WORD, WORD);
    @(negedge clk);
    chk("t4_gnt", {31'h0, p0_gnt}, 32'h1);
    tick();
    idle_all();
    @(negedge clk);
    chk("t4_mem_rd", {30'h0, mem_rd}, {30'h0, MEM_NONE});
    chk("t4_mem_wr", {30'h0, mem_wr}, {30'h0, WORD});
    tick();
    tick();
    drive0(1'b1, 8'h40, 32'h0, WORD, MEM_NONE);
    @(negedge clk);
    chk("t4_rd_gnt", {31'h0, p0_gnt}, 32'h1);
    expect_read(1'b0, 32'h55AA55AA);
    tick();
    idle_all();
    repeat (3) tick();

    // Both ports request continuously: port 1 wins in cycles 5 and 10.
    drive0(1'b1, 8'h10, 32'h0, WORD, MEM_NONE);
    drive1(1'b1, 8'h20, 32'h0, WORD, MEM_NONE);
    for (int k = 1; k <= 10; k++) begin
      logic exp1;
      exp1 = (k == 5) || (k == 10);
      @(negedge clk);
      chk($sformatf("t5_p1_gnt_k%0d", k), {31'h0, p1_gnt}, {31'h0, exp1});
      chk($sformatf("t5_p0_gnt_k%0d", k), {31'h0, p0_gnt}, {31'h0, ~exp1});
      chk($sformatf("t5_stall_k%0d", k), {31'h0, p0_stall}, {31'h0, exp1});
      if (exp1) expect_read(1'b1, 32'hCAFEF00D);
      else      expect_read(1'b0, 32'hDEADBEEF);
      tick();
    end
    idle_all();
    repeat (4) tick();

    // Reset during the access cycle of a write.
    drive0(1'b1, 8'h50, 32'h12345678, MEM_NONE, WORD);
    @(negedge clk);
    chk("t6_wr_gnt", {31'h0, p0_gnt}, 32'h1);
    tick();
    idle_all();
    drive1(1'b1, 8'h10, 32'h0, WORD, MEM_NONE);
    n_rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_mem_wr", {30'h0, mem_wr}, {30'h0, MEM_NONE});
    chk("t6_rst_p1_gnt", {31'h0, p1_gnt}, 32'h0);
    tick();
    n_rst = 1'b1;
    idle_all();
    @(negedge clk);
    chk("t6_mem_addr", {24'h0, mem_addr}, 32'h0);
    chk("t6_mem_wd", mem_wd, 32'h0);
    chk("t6_mem_wr", {30'h0, mem_wr}, {30'h0, MEM_NONE});
    chk("t6_mem_rd", {30'h0, mem_rd}, {30'h0, MEM_NONE});
    chk("t6_p0_rvalid", {31'h0, p0_rvalid}, 32'h0);
    chk("t6_p1_rvalid", {31'h0, p1_rvalid}, 32'h0);
    chk("t6_p0_rdata", p0_rdata, 32'h0);
    chk("t6_p1_rdata", p1_rdata, 32'h0);
    chk("t6_mem_word", mem_model[8'h50], 32'h0);

    repeat (4) tick();
    chk("sb_drained", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single data memory between the pipeline MEM stage (port 0) and a debug/loader port (port 1). Each cycle it picks one request by fixed priority with a starvation guard, registers the command, drives the memory's address/data/size-control inputs for one cycle, and returns registered read data with a valid pulse. It sits between the MEM stage and the data memory, replacing the direct connection between them. Throughput is one access per cycle.

## Interface
- `MAX_WAIT`, 4: consecutive cycles port 1 may be refused before it is forced to win; legal range 1..15.
- `clk_i` in 1: single clock; all state updates on rising edge.
- `n_rst_i` in 1: synchronous, active-low reset.
- `p0_req_i` / `p1_req_i` in 1: request; held with its fields stable until granted.
- `p0_address_i` / `p1_address_i` in 8: word address.
- `p0_write_data_i` / `p1_write_data_i` in 32: store data.
- `p0_ctrl_mem_read_i` / `p1_ctrl_mem_read_i` in 2: read size code.
- `p0_ctrl_mem_write_i` / `p1_ctrl_mem_write_i` in 2: write size code.
- `p0_gnt_o` / `p1_gnt_o` out 1: combinational; the request is accepted this cycle.
- `p0_stall_o` out 1: `p0_req_i & ~p0_gnt_o`; stalls the pipeline.
- `p0_read_data_o` / `p1_read_data_o` out 32: registered read data.
- `p0_rvalid_o` / `p1_rvalid_o` out 1: one-cycle pulse; read data valid.
- `mem_address_o` out 8: to memory.
- `mem_write_data_o` out 32: to memory.
- `mem_ctrl_mem_read_o` / `mem_ctrl_mem_write_o` out 2: to memory.
- `mem_read_data_i` in 32: combinational read data from memory.

## Operation
- Size codes are the shared `WORD`, `HALFWORD` and `BYTE` constants. Any other value means no access.
- A request whose read and write codes are both valid is treated as a write. Its read code is forced to no-access and it produces no rvalid.
- A request with neither code valid is granted as a no-op.
- Arbitration:
  - Port 0 wins by default.
  - Port 1 wins when port 0 is idle, or when `wait_cnt == MAX_WAIT` and both ports request.
- `wait_cnt`:
  - Increments, saturating at `MAX_WAIT`, each cycle `p1_req_i & ~p1_gnt_o`.
  - Clears on a port 1 grant or when `p1_req_i` is low.
- Command register holds valid, port id, address, write data, read code and write code. It loads the winner on every grant and clears valid when there is no grant.
- `mem_*` outputs are driven from the command register. When valid = 0 or `n_rst_i` = 0, the ctrl outputs are no-access and address/data are 0.
- Read-data register captures `mem_read_data_i` at the end of the access cycle. The matching `pX_rvalid_o` is set only for reads. Read data holds its value until the next read completes.
- Reset (synchronous, `n_rst_i` = 0 at a rising edge) clears command valid, `wait_cnt`, both rvalid, and both read data to 0.
- Grants, stall and memory ctrl are combinationally gated to 0 while `n_rst_i` = 0. An access in flight during reset therefore commits no write and yields no rvalid.

## Timing
- Cycle N: request present, gnt asserted in the same cycle, command latched at the end of N.
- Cycle N+1: memory inputs driven. A write commits at the memory's edge ending N+1; read data is sampled at the end of N+1.
- Cycle N+2: rvalid = 1 with read data. Read latency is 2 cycles from grant.
- Back-to-back grants are allowed. A read in N+1 to the address written in N observes the new data.
- A loser keeps its request asserted. Port 1 worst-case wait under continuous port 0 traffic is `MAX_WAIT` cycles, granted in cycle `MAX_WAIT`+1.

## Structure
- The shared header holds the size codes and `MEM_ADDR_W` = 8. No new typedefs are needed.
- One sub-module is natural: `starve_counter`, a saturating counter with inc, clr and at_max signals, parameterized by `MAX_WAIT`.
- The arbiter mux, command register and read-data register live in the top module.

## Test plan
- Port 0 `WORD` write 0xDEADBEEF to address 0x10, then `WORD` read of 0x10 → `p0_gnt_o` same cycle, `p0_rvalid_o` 2 cycles after the read grant, data 0xDEADBEEF.
- Both ports request continuously, `MAX_WAIT`=4 → port 0 wins 4 cycles, port 1 wins cycle 5, `wait_cnt` returns to 0, `p0_stall_o`=1 in cycle 5 only.
- Port 1 `BYTE` read of a word holding 0x00000080 → `p1_read_data_o` = 0xFFFFFF80, `p0_rvalid_o` stays 0.
- Request with both read and write = `WORD` → write commits, no rvalid on either port.
- `n_rst_i` low during the access cycle of a write of 0x12345678 → memory word unchanged, all outputs 0 the following cycle.
- Write in N to address 0x20, read in N+1 of 0x20 → new data returned at N+3.
